// File: rtl/fasta_base_streamer.sv
// FASTA front end for ScoringModule: packs the first record into a 2-bit query
// register, then streams each later record one base per cycle with an idle gap.
module fasta_base_streamer #(
    parameter int QUERY_MAX  = 50,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [0:2*QUERY_MAX-1] query,
    output logic [6:0]             query_len,
    output logic                   query_vld,
    output logic [1:0]             data_out,
    output logic                   en_out,
    output logic                   seq_end,
    output logic [CNT_WIDTH-1:0]   rec_count,
    output logic [2:0]             err
);

    localparam int QCW = $clog2(QUERY_MAX + 1);
    localparam int QIW = (QUERY_MAX > 1) ? $clog2(QUERY_MAX) : 1;
    localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [QCW-1:0] QMAX     = QCW'(QUERY_MAX);
    localparam logic [GCW-1:0] GAP_LOAD = GCW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        Q_WAIT = 3'd0,
        Q_HDR  = 3'd1,
        Q_SEQ  = 3'd2,
        D_WAIT = 3'd3,
        D_HDR  = 3'd4,
        D_SEQ  = 3'd5,
        D_GAP  = 3'd6
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [1:0]           r_qbase [0:QUERY_MAX-1];
    logic [QCW-1:0]       r_qcnt;
    logic [6:0]           r_qlen;
    logic                 r_qvld;
    logic [1:0]           r_data;
    logic                 r_en;
    logic                 r_seq_end;
    logic [CNT_WIDTH-1:0] r_rec_cnt;
    logic [2:0]           r_err;
    logic                 r_seen;
    logic                 r_pend_hdr;
    logic [GCW-1:0]       r_gap_cnt;

    logic       w_is_lf;
    logic       w_is_gt;
    logic       w_is_ign;
    logic       w_is_base;
    logic [1:0] w_code;
    logic       w_acc;
    logic       w_q_base;
    logic       w_q_wr;
    logic       w_q_lf;
    logic       w_d_base;
    logic       w_d_term;
    logic       w_rec_end;
    logic       w_gap_done;
    logic       w_set_ill;
    logic       w_set_ovf;
    logic       w_set_emp;

    // Byte classification and 2-bit base encoding
    always_comb begin
        w_is_lf   = (s_data == 8'h0A);
        w_is_gt   = (s_data == 8'h3E);
        w_is_ign  = (s_data == 8'h0D) || (s_data == 8'h20);
        w_is_base = 1'b1;
        w_code    = 2'b00;
        case (s_data)
            8'h41, 8'h61: w_code = 2'b00;
            8'h47, 8'h67: w_code = 2'b01;
            8'h54, 8'h74: w_code = 2'b10;
            8'h43, 8'h63: w_code = 2'b11;
            default:      w_is_base = 1'b0;
        endcase
    end

    assign w_acc      = s_valid && s_ready;
    assign w_gap_done = (r_gap_cnt == '0);

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= Q_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            Q_WAIT: if (w_acc && w_is_gt) w_state_next = Q_HDR;
            Q_HDR:  if (w_acc && w_is_lf) w_state_next = Q_SEQ;
            Q_SEQ: begin
                if (w_acc && w_is_lf) begin
                    w_state_next = (r_qcnt != '0) ? D_WAIT : Q_WAIT;
                end
            end
            D_WAIT: if (w_acc && w_is_gt) w_state_next = D_HDR;
            D_HDR:  if (w_acc && w_is_lf) w_state_next = D_SEQ;
            D_SEQ: begin
                // A stray '>' closes the record and also opens the next header
                if (w_acc && (w_is_lf || w_is_gt)) begin
                    if (r_seen) begin
                        w_state_next = D_GAP;
                    end else begin
                        w_state_next = w_is_gt ? D_HDR : D_WAIT;
                    end
                end
            end
            D_GAP: begin
                if (w_gap_done) begin
                    w_state_next = r_pend_hdr ? D_HDR : D_WAIT;
                end
            end
            default: w_state_next = Q_WAIT;
        endcase
    end

    // FSM: outputs and per-state strobes
    always_comb begin
        s_ready   = (r_state != D_GAP);
        w_q_base  = 1'b0;
        w_q_lf    = 1'b0;
        w_d_base  = 1'b0;
        w_d_term  = 1'b0;
        w_set_ill = 1'b0;
        if (s_valid && (r_state != D_GAP)) begin
            w_q_base = (r_state == Q_SEQ) && w_is_base;
            w_q_lf   = (r_state == Q_SEQ) && w_is_lf;
            w_d_base = (r_state == D_SEQ) && w_is_base;
            w_d_term = (r_state == D_SEQ) && (w_is_lf || w_is_gt);
            if (!w_is_ign) begin
                w_set_ill = (((r_state == Q_WAIT) || (r_state == D_WAIT)) && !w_is_gt) ||
                            (((r_state == Q_SEQ) || (r_state == D_SEQ)) && !w_is_base && !w_is_lf);
            end
        end
        w_q_wr    = w_q_base && (r_qcnt != QMAX);
        w_set_ovf = w_q_base && (r_qcnt == QMAX);
        w_rec_end = w_d_term && r_seen;
        w_set_emp = (w_q_lf && (r_qcnt == '0)) || (w_d_term && !r_seen);
    end

    // Query capture; the register only changes while in Q_SEQ, so it is frozen afterwards
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < QUERY_MAX; i++) begin
                r_qbase[i] <= 2'b00;
            end
            r_qcnt <= '0;
            r_qlen <= '0;
            r_qvld <= 1'b0;
        end else begin
            if (w_q_wr) begin
                r_qbase[r_qcnt[QIW-1:0]] <= w_code;
                r_qcnt                   <= r_qcnt + QCW'(1);
            end
            if (w_q_lf && (r_qcnt != '0)) begin
                r_qlen <= 7'(r_qcnt) - 7'd1;
                r_qvld <= 1'b1;
            end
        end
    end

    // Database stream, record bookkeeping and sticky error flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data     <= 2'b00;
            r_en       <= 1'b0;
            r_seq_end  <= 1'b0;
            r_rec_cnt  <= '0;
            r_err      <= 3'b000;
            r_seen     <= 1'b0;
            r_pend_hdr <= 1'b0;
            r_gap_cnt  <= '0;
        end else begin
            r_en      <= w_d_base;
            r_seq_end <= w_rec_end;
            if (w_d_base) begin
                r_data <= w_code;
            end
            if (w_rec_end) begin
                r_rec_cnt <= r_rec_cnt + CNT_WIDTH'(1);
            end
            if (w_d_base) begin
                r_seen <= 1'b1;
            end else if (w_d_term) begin
                r_seen <= 1'b0;
            end
            if (w_d_term) begin
                r_pend_hdr <= w_is_gt;
            end
            // The seq_end cycle is the first gap cycle, hence the load of GAP_CYCLES-1
            if (w_rec_end) begin
                r_gap_cnt <= GAP_LOAD;
            end else if ((r_state == D_GAP) && !w_gap_done) begin
                r_gap_cnt <= r_gap_cnt - GCW'(1);
            end
            r_err <= r_err | {w_set_emp, w_set_ovf, w_set_ill};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < QUERY_MAX; gi++) begin : g_query
            assign query[2*gi +: 2] = r_qbase[gi];
        end
    endgenerate

    assign query_len = r_qlen;
    assign query_vld = r_qvld;
    assign data_out  = r_data;
    assign en_out    = r_en;
    assign seq_end   = r_seq_end;
    assign rec_count = r_rec_cnt;
    assign err       = r_err;

endmodule

// File: tb/tb_fasta_base_streamer.sv
// Scoreboard bench for fasta_base_streamer: stimulus queues expected stream events,
// a negedge monitor pops and compares them and records s_ready low runs.
module tb_fasta_base_streamer;

    localparam int QM  = 50;
    localparam int GAP = 3;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic [0:2*QM-1] query;
    logic [6:0]    query_len;
    logic          query_vld;
    logic [1:0]    data_out;
    logic          en_out;
    logic          seq_end;
    logic [CW-1:0] rec_count;
    logic [2:0]    err;

    int checks = 0;
    int errors = 0;

    // {is_end, code}
    logic [2:0] exp_q[$];
    int         gap_q[$];
    int         low_run = 0;

    fasta_base_streamer #(
        .QUERY_MAX (QM),
        .GAP_CYCLES(GAP),
        .CNT_WIDTH (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .query    (query),
        .query_len(query_len),
        .query_vld(query_vld),
        .data_out (data_out),
        .en_out   (en_out),
        .seq_end  (seq_end),
        .rec_count(rec_count),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic expb(input logic [1:0] c);
        exp_q.push_back({1'b0, c});
    endtask

    task automatic expe();
        exp_q.push_back(3'b100);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n       = 0;
        s_data  = b;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_ready=0 after %0d cycles, expected 1 (byte 0x%0h)", n, b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
        end
    endtask

    task automatic send_stalled(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            s_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_gaps(input string name, input int n_exp);
        check({name, "_gap_runs"}, gap_q.size(), n_exp);
        foreach (gap_q[i]) begin
            check({name, "_gap_len"}, gap_q[i], GAP);
        end
        gap_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_query"},     query,     '0);
        check({name, "_query_len"}, query_len, 0);
        check({name, "_query_vld"}, query_vld, 0);
        check({name, "_data_out"},  data_out,  0);
        check({name, "_en_out"},    en_out,    0);
        check({name, "_seq_end"},   seq_end,   0);
        check({name, "_rec_count"}, rec_count, 0);
        check({name, "_err"},       err,       0);
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        gap_q.delete();
    endtask

    // Monitor: every en_out or seq_end cycle must match the head of the queue
    always @(negedge clk) begin : monitor
        logic [2:0] e;
        logic       ok;
        if (rst && (en_out || seq_end)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stream: unexpected event en_out=%0b seq_end=%0b data_out=%b, expected none",
                         en_out, seq_end, data_out);
            end else begin
                e = exp_q.pop_front();
                if (e[2]) begin
                    ok = seq_end && !en_out;
                end else begin
                    ok = en_out && !seq_end && (data_out == e[1:0]);
                end
                if (!ok) begin
                    errors++;
                    $display("FAIL stream: got en_out=%0b seq_end=%0b data_out=%b, expected %s %b",
                             en_out, seq_end, data_out, e[2] ? "seq_end" : "base", e[1:0]);
                end else begin
                    $display("ok   stream %s %b", e[2] ? "seq_end" : "base", e[1:0]);
                end
            end
        end
        if (!s_ready) begin
            low_run++;
        end else if (low_run > 0) begin
            gap_q.push_back(low_run);
            low_run = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        #2 rst = 1'b0;
        #2;
        check_reset_outputs("reset");
        release_reset();

        // Basic: query ACGT, one record GGTA
        expb(2'b01); expb(2'b01); expb(2'b10); expb(2'b00); expe();
        send_str(">q\nACGT\n>d0\nGGTA\n");
        idle(10);
        @(negedge clk);
        check("basic_query", query[0:7], 8'b00_11_01_10);
        check("basic_query_len", query_len, 3);
        check("basic_query_vld", query_vld, 1);
        check("basic_rec_count", rec_count, 1);
        check("basic_err", err, 0);
        check("basic_drain", exp_q.size(), 0);
        check_gaps("basic", 1);

        // Gap and back-to-back with s_valid held high
        expb(2'b00); expb(2'b11); expe();
        expb(2'b10); expe();
        send_str(">a\nAC\n>b\nT\n");
        idle(10);
        @(negedge clk);
        check("b2b_rec_count", rec_count, 3);
        check("b2b_query_frozen", query[0:7], 8'b00_11_01_10);
        check("b2b_query_len_frozen", query_len, 3);
        check("b2b_drain", exp_q.size(), 0);
        check_gaps("b2b", 2);

        // Stall and noise: lowercase, CR, s_valid toggled
        send_str(">s\n");
        expb(2'b00); expb(2'b11); expb(2'b01); expb(2'b10); expe();
        send_stalled("acgt\015\n");
        idle(10);
        @(negedge clk);
        check("stall_rec_count", rec_count, 4);
        check("stall_err", err, 0);
        check("stall_drain", exp_q.size(), 0);
        check_gaps("stall", 1);

        // Overflow and empty record after a fresh reset
        @(negedge clk);
        rst = 1'b0;
        release_reset();
        send_str(">q\n");
        for (int i = 0; i < 13; i++) begin
            send_str("ACGT");
        end
        send_str("\n>e\n\n");
        idle(10);
        @(negedge clk);
        check("ovf_query_len", query_len, 49);
        check("ovf_query_vld", query_vld, 1);
        check("ovf_query_head", query[0:7], 8'b00_11_01_10);
        check("ovf_query_last", query[98:99], 2'b11);
        check("ovf_err", err, 3'b110);
        check("ovf_rec_count", rec_count, 0);
        check("ovf_drain", exp_q.size(), 0);
        check_gaps("ovf", 0);

        // Illegal char inside a record, then reset mid-record
        expb(2'b01); expb(2'b10);
        send_str(">d\nGNT");
        idle(4);
        @(negedge clk);
        check("ill_err", err, 3'b111);
        check("ill_data_out", data_out, 2'b10);
        check("ill_drain", exp_q.size(), 0);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        release_reset();

        // New query accepted after reset
        expb(2'b11); expe();
        send_str(">z\nTTA\n>y\nC\n");
        idle(10);
        @(negedge clk);
        check("requery_query", query[0:5], 6'b10_10_00);
        check("requery_query_len", query_len, 2);
        check("requery_query_vld", query_vld, 1);
        check("requery_rec_count", rec_count, 1);
        check("requery_err", err, 0);
        check("requery_drain", exp_q.size(), 0);
        check_gaps("requery", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fasta_base_streamer.md
Name: fasta_base_streamer

Overview:
- Upstream feeder for ScoringModule.
- Parses an ASCII FASTA byte stream; the first record is the query, and every later record is a database sequence.
- Packs the query into the 2-bit-per-base bitstream ScoringModule loads as its query.
- Streams database bases one per cycle on data_out/en_out, with at least GAP_CYCLES idle cycles between records so ScoringModule can close each alignment.

Parameters:
- QUERY_MAX, 50: maximum query length in bases; the query register is 2*QUERY_MAX bits.
- GAP_CYCLES, 1: idle cycles (en_out=0, s_ready=0) forced after each database record; legal range >=1.
- CNT_WIDTH, 16: width of rec_count.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- s_data  in  8  ASCII input byte.
- s_valid  in  1  s_data valid.
- s_ready  out  1  byte accepted when s_valid&&s_ready.
- query  out  2*QUERY_MAX, indexed [0:2*QUERY_MAX-1]  packed query; base i occupies bits [2i:2i+1].
- query_len  out  7  number of query bases minus 1.
- query_vld  out  1  query register complete and stable.
- data_out  out  2  database base code, to ScoringModule data_in.
- en_out  out  1  data_out valid, to ScoringModule en_in.
- seq_end  out  1  one-cycle pulse marking end of a database record.
- rec_count  out  CNT_WIDTH  database records streamed (non-empty only).
- err  out  3  sticky flags: [0] illegal char, [1] query overflow, [2] empty record.

Behaviour:
- Encoding:
  - A/a=00, G/g=01, T/t=10, C/c=11.
  - CR (0x0D) and space (0x20) are ignored in every state.
  - LF is 0x0A.
- Reset (rst=0, async): state=Q_WAIT; all outputs 0; query and query_len cleared; err cleared. Reset mid-record discards everything, and the query must be resent.
- States and transitions (one byte consumed per handshake):
  - Q_WAIT: '>' goes to Q_HDR; any other non-ignored byte sets err[0] and is dropped.
  - Q_HDR: bytes discarded until LF, then Q_SEQ.
  - Q_SEQ: each base is written at index qcnt and qcnt increments.
    - LF with qcnt>0: query_len=qcnt-1, query_vld=1 from the next cycle, go to D_WAIT.
    - LF with qcnt=0: set err[2], go to Q_WAIT.
    - Bases beyond QUERY_MAX are dropped and set err[1]; query_len saturates at QUERY_MAX-1.
  - D_WAIT: '>' goes to D_HDR; other non-ignored bytes set err[0].
  - D_HDR: discard until LF, then D_SEQ.
  - D_SEQ:
    - Each accepted base: data_out=code and en_out=1 on the following cycle (1-cycle registered latency).
    - Cycles with no accepted base drive en_out=0; data_out holds its last value.
    - LF after >=1 base: seq_end=1 for exactly one cycle (the cycle after LF is accepted, en_out=0); rec_count increments in the same cycle; go to D_GAP.
    - LF after 0 bases: set err[2]; no seq_end; rec_count unchanged; no gap; go to D_WAIT.
    - '>' in D_SEQ is illegal (records must be LF-terminated): set err[0]; treated as LF followed by '>'.
  - D_GAP:
    - s_ready=0 for exactly GAP_CYCLES cycles, counted starting with the seq_end cycle; then D_WAIT.
  - Illegal chars in the HDR states are never flagged.
- s_ready:
  - 1 in all states except D_GAP.
  - Combinational from state only, with no dependence on s_valid.
- query and query_len are frozen once query_vld=1, until reset.
- rec_count wraps modulo 2^CNT_WIDTH.
- err bits are sticky until reset.

Test Plan:
- Basic:
  - Stimulus: ">q\nACGT\n>d0\nGGTA\n".
  - Response:
    - query[0:7]=8'b00_11_01_10, query_len=3, query_vld=1.
    - en_out high for 4 consecutive cycles with data_out 01,01,10,00.
    - seq_end pulses once on the next cycle; rec_count=1.
- Gap and back-to-back:
  - Stimulus: GAP_CYCLES=3; two records "AC", "T" sent with s_valid held high.
  - Response: s_ready=0 for exactly 3 cycles after each record; en_out patterns 1,1 then 1; rec_count=2.
- Stall and noise:
  - Stimulus: s_valid toggled every other cycle inside D_SEQ for "acgt\r\n", lowercase input.
  - Response: en_out=1 only on the cycles after accepted bases; codes 00,11,01,10; CR ignored; err=0.
- Overflow and empty record:
  - Stimulus: 52-base query followed by record ">e\n\n".
  - Response: query_len=49; err[1]=1; err[2]=1; no seq_end; rec_count=0.
- Illegal char and reset:
  - Stimulus: "N" inside a database sequence, then rst=0 asserted mid-record.
  - Response: err[0]=1; the N byte is dropped with no en_out. Immediately on reset: all outputs 0, query_vld=0, state Q_WAIT; a new query is accepted afterwards.
